// File: rtl/word_serializer_if.sv
// Word-in / byte-frame-out bus of the word serializer.
// The master side offers words and watches the frame bus; the slave side is the serializer.
interface word_serializer_if;
  logic        in_valid;
  logic [31:0] Din;
  logic        in_ready;
  logic        Cout;
  logic        Vout;
  logic [7:0]  Dout;
  logic        Done;
  logic        Busy;

  modport master (
    output in_valid, Din,
    input  in_ready, Cout, Vout, Dout, Done, Busy
  );

  modport slave (
    input  in_valid, Din,
    output in_ready, Cout, Vout, Dout, Done, Busy
  );
endinterface

// File: rtl/word_serializer.sv
// Serializes 32-bit words into back-to-back byte frames with one pending-word buffer and an idle gap.
// Optional macro SERIALIZER_PARITY_EN appends an XOR checksum byte, giving 5-byte frames.
module word_serializer #(
  parameter bit          MSB_FIRST  = 1'b1,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  word_serializer_if.slave bus
);

`ifdef SERIALIZER_PARITY_EN
  localparam int unsigned CW   = 3;
  localparam logic [CW-1:0] LAST = 3'd4;
`else
  localparam int unsigned CW   = 2;
  localparam logic [CW-1:0] LAST = 2'd3;
`endif
  localparam bit         HAS_GAP  = (GAP_CYCLES != 0);
  localparam logic [3:0] GAP_LAST = 4'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    gap_q, gap_d;
  logic [31:0]   sh_q, sh_d;
  logic [31:0]   pend_q, pend_d;
  logic          pend_v_q, pend_v_d;
  logic          cout_q, cout_d;
  logic          vout_q, vout_d;
  logic [7:0]    dout_q, dout_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
`ifdef SERIALIZER_PARITY_EN
  logic [7:0]    par_q, par_d;
`endif

  logic          accept;
  logic          avail;
  logic          load;
  logic [31:0]   ld_word;

  function automatic logic [7:0] first_byte(input logic [31:0] w);
    return MSB_FIRST ? w[31:24] : w[7:0];
  endfunction

  // Drops the byte just emitted so the next one sits at the output end.
  function automatic logic [31:0] shift_out(input logic [31:0] w);
    return MSB_FIRST ? {w[23:0], 8'h00} : {8'h00, w[31:8]};
  endfunction

  always_comb begin
    accept   = bus.in_valid && !pend_v_q;
    avail    = pend_v_q || bus.in_valid;
    ld_word  = pend_v_q ? pend_q : bus.Din;
    load     = 1'b0;
    state_d  = state_q;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    sh_d     = sh_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    cout_d   = 1'b0;
    vout_d   = 1'b0;
    dout_d   = 8'h00;
    done_d   = 1'b0;
`ifdef SERIALIZER_PARITY_EN
    par_d    = par_q;
`endif

    case (state_q)
      IDLE: load = avail;
      SEND: begin
        if (cnt_q != LAST) begin
          cnt_d  = cnt_q + CW'(1);
          vout_d = 1'b1;
          done_d = (cnt_d == LAST);
          sh_d   = shift_out(sh_q);
`ifdef SERIALIZER_PARITY_EN
          dout_d = (cnt_d == LAST) ? par_q : first_byte(sh_q);
`else
          dout_d = first_byte(sh_q);
`endif
        end else if (HAS_GAP) begin
          state_d = GAP;
          gap_d   = 4'd0;
        end else if (avail) begin
          load = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      GAP: begin
        if (gap_q != GAP_LAST) gap_d = gap_q + 4'd1;
        else if (avail)        load  = 1'b1;
        else                   state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Byte 0 is registered on the load edge, so the shifter keeps only the rest.
    if (load) begin
      state_d = SEND;
      cnt_d   = '0;
      sh_d    = shift_out(ld_word);
      cout_d  = 1'b1;
      vout_d  = 1'b1;
      dout_d  = first_byte(ld_word);
`ifdef SERIALIZER_PARITY_EN
      par_d   = ld_word[31:24] ^ ld_word[23:16] ^ ld_word[15:8] ^ ld_word[7:0];
`endif
    end

    // A word skips the buffer only when the shifter takes it on this very edge.
    if (load && pend_v_q) begin
      pend_v_d = 1'b0;
    end else if (accept && !load) begin
      pend_v_d = 1'b1;
      pend_d   = bus.Din;
    end

    busy_d = (state_d != IDLE) || pend_v_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      gap_q    <= 4'd0;
      sh_q     <= 32'h0;
      pend_q   <= 32'h0;
      pend_v_q <= 1'b0;
      cout_q   <= 1'b0;
      vout_q   <= 1'b0;
      dout_q   <= 8'h00;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      par_q    <= 8'h00;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gap_q    <= gap_d;
      sh_q     <= sh_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      cout_q   <= cout_d;
      vout_q   <= vout_d;
      dout_q   <= dout_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
`ifdef SERIALIZER_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  assign bus.in_ready = !pend_v_q;
  assign bus.Cout     = cout_q;
  assign bus.Vout     = vout_q;
  assign bus.Dout     = dout_q;
  assign bus.Done     = done_q;
  assign bus.Busy     = busy_q;

endmodule

// File: doc/word_serializer.md
Name: word_serializer

Overview:
- Transmit-side counterpart of the byte-stream deserializer.
- Accepts 32-bit words over a valid/ready handshake and emits each word as a 4-byte frame on an 8-bit bus.
- Cout strobes with the first byte of each frame, and the remaining bytes follow on consecutive cycles with no gaps.
- Includes one pending-word buffer so frames can go out back-to-back, plus a configurable inter-frame idle gap.

Parameters:
MSB_FIRST, 1, 1: byte order [31:24],[23:16],[15:8],[7:0]; 0: [7:0] first.
GAP_CYCLES, 0, minimum idle cycles between the last byte of one frame and Cout of the next (0..15).

Ports:
clk  in  1  clock; all logic on posedge.
rst_n  in  1  synchronous, active-low reset.
in_valid  in  1  Din word valid.
Din  in  32  word to transmit.
in_ready  out  1  word accepted when in_valid && in_ready.
Cout  out  1  frame start; high only during the cycle carrying byte 0.
Vout  out  1  Dout carries a valid frame byte.
Dout  out  8  frame byte; 0 whenever Vout=0.
Done  out  1  one-cycle pulse coincident with the last byte of a frame.
Busy  out  1  frame in progress, gap counting, or pending word held.

Behaviour:
- Reset (rst_n=0 at posedge): Cout=0, Vout=0, Dout=0, Done=0, Busy=0, in_ready=1. Shift register, pending buffer, byte counter and gap counter are all cleared.
- Reset mid-frame aborts the frame immediately and discards the pending word. There is no partial-frame completion.
- State machine: IDLE, SEND, GAP.
- IDLE → SEND: accepted word, or pending word present. Frame data is loaded into the shift register and the byte counter is set to 0.
- SEND: one byte per cycle; the counter runs 0..3. At counter 3, Done=1.
  - Next state is SEND if a word is available and GAP_CYCLES=0.
  - Next state is GAP if GAP_CYCLES>0.
  - Otherwise next state is IDLE.
- GAP: counts GAP_CYCLES cycles with Vout=0. After that it goes to SEND if a word is available, else IDLE.
- Latency: a word accepted at edge N, with the shifter free, yields Cout/Vout high with byte 0 in the cycle after edge N. Bytes 0..3 occupy 4 consecutive cycles.
- All outputs are registered.
- Load priority: pending buffer first, then the direct input. An accepted word goes directly to the shifter only if the shifter loads this cycle and the pending buffer is empty; otherwise it goes to the pending buffer.
- in_ready = !pend_valid.
  - The pending slot is freed on the same edge that the shifter loads from it.
  - in_ready rises the following cycle, so there is no combinational path from in_valid to in_ready.
- Simultaneous events:
  - Last byte plus a new word accepted in the same cycle: the new word loads directly for the next cycle (GAP_CYCLES=0).
  - Shifter loading from pending plus a new word accepted: illegal (in_ready=0).
- in_valid while in_ready=0 is ignored. Din need not be held stable after acceptance.
- Busy = (state != IDLE) || pend_valid.
- Byte counter: 2 bits, wraps 3→0 only on a new frame load.
- Gap counter: 4 bits. GAP_CYCLES=0 must synthesize to no gap state entry.

Optional Feature:
- Macro: SERIALIZER_PARITY_EN.
- Defined: each frame is 5 bytes.
  - Byte 4 is an XOR checksum of bytes 0..3, emitted the cycle after byte 3.
  - Done moves to the checksum byte; the byte counter is extended to 0..4.
  - Back-to-back frames repeat every 5 cycles.
- Undefined: 4-byte frames exactly as above, with no checksum logic present.

Test Plan:
- Single word, MSB_FIRST=1: Din=0xA1B2C3D4 accepted at edge 0 → cycles 1–4 Dout=A1,B2,C3,D4, Vout=1; Cout=1 only in cycle 1; Done=1 only in cycle 4; cycle 5 Vout=0, Dout=0, Busy=0.
- Back-to-back, GAP_CYCLES=0: words 0x11223344 then 0x55667788 with in_valid held high → 8 contiguous bytes 11..88; Cout in cycles 1 and 5; Done in cycles 4 and 8; in_ready=0 while the second word is pending.
- Backpressure: three words offered continuously → third accepted only after the first frame's last byte; no byte lost or duplicated; output order preserved.
- GAP_CYCLES=2, MSB_FIRST=0: two words 0xA1B2C3D4 and 0x01020304 back-to-back → D4,C3,B2,A1, then 2 cycles Vout=0, then 04,03,02,01.
- Reset mid-frame: rst_n=0 during the byte-1 cycle with a pending word → next cycle all outputs 0, in_ready=1; the pending word is never transmitted.
- SERIALIZER_PARITY_EN defined: Din=0xA1B2C3D4 → Dout=A1,B2,C3,D4,04; Done on 0x04 only; next frame Cout 5 cycles after the previous one.
